pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised fetch-stage program counter for the pipelined RISC-V core; next generation of the plain PC register.
- Holds the current fetch address and selects the next PC by fixed priority: trap, EX-stage redirect, stall hold, BTB prediction, sequential PC+4.
- Contains a small direct-mapped branch target buffer (BTB). The BTB is looked up on the current PC and trained by the EX stage.

Parameters:
- XLEN, 32, width of PC and all address ports.
- RESET_VECTOR, 32'h00000000, value loaded into pc_out on reset.
- BTB_ENTRIES, 16, number of BTB entries. Must be a power of two and at least 2.
- BTB_EN, 1, 1 enables prediction; 0 forces pred_taken=0 and the next PC never comes from the BTB.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- stall_f  input  1  hazard-unit fetch stall; hold PC.
- trap_valid  input  1  exception/interrupt redirect request.
- trap_pc  input  XLEN  trap handler address.
- redirect_valid  input  1  EX-stage mispredict/jump redirect.
- redirect_pc  input  XLEN  corrected target.
- btb_upd_valid  input  1  BTB training strobe from EX.
- btb_upd_pc  input  XLEN  address of the resolved branch/jump.
- btb_upd_taken  input  1  resolved direction.
- btb_upd_target  input  XLEN  resolved taken target.
- pc_out  output  XLEN  current fetch PC.
- pc_plus4  output  XLEN  pc_out+4, combinational.
- pred_taken  output  1  BTB hit on pc_out, combinational.
- pred_target  output  XLEN  predicted target on a hit; 0 on a miss.

Behaviour:
- Reset, synchronous and active-high:
  - pc_out <= RESET_VECTOR.
  - All BTB valid bits are cleared. Tags and targets need not be reset.
  - Reset overrides every other input in the same cycle.
- Address split:
  - idx = pc[IDX_W+1:2], where IDX_W = log2(BTB_ENTRIES).
  - tag = pc[XLEN-1:IDX_W+2].
  - Bits [1:0] are ignored for lookup and update.
- Lookup (combinational on pc_out):
  - hit = BTB_EN & valid[idx] & (tag_mem[idx] == tag).
  - pred_taken = hit.
  - pred_target = hit ? target_mem[idx] : 0.
- Next-PC priority, applied each rising edge when reset=0:
  1. trap_valid: pc_out <= {trap_pc[XLEN-1:2],2'b00}.
  2. redirect_valid: pc_out <= {redirect_pc[XLEN-1:2],2'b00}.
  3. stall_f: pc_out holds.
  4. hit: pc_out <= pred_target.
  5. otherwise: pc_out <= pc_plus4.
- trap_valid and redirect_valid both override stall_f, because a flush must not be lost to a stall.
- trap_valid and redirect_valid in the same cycle: the trap wins.
- Arithmetic:
  - pc_plus4 = pc_out + 4, modulo 2^XLEN.
  - At the top of the address space, 32'hFFFFFFFC -> 32'h00000000. No wrap flag.
- BTB update, on the rising edge, independent of stall_f and of redirects:
  - btb_upd_valid & btb_upd_taken: write valid=1, tag and target at the update index, overwriting any alias. Target bits [1:0] are stored as 0.
  - btb_upd_valid & ~btb_upd_taken: if the entry at the update index is valid and its tag matches, clear its valid bit. Otherwise no change.
  - Update and lookup to the same index in the same cycle: the lookup sees the pre-update contents. Write-first bypass is not allowed.
  - Update during reset is ignored.
- Latency:
  - A redirect or trap appears on pc_out exactly 1 cycle after assertion.
  - A BTB entry written at edge N can produce a hit on the pc_out value present after edge N.
- Mid-operation reset discards all predictor state. The first fetch after reset is RESET_VECTOR with pred_taken=0.

Test Plan:
- Reset and sequential flow: assert reset 2 cycles with RESET_VECTOR=0, release, no other inputs -> pc_out 0,4,8,C on successive cycles; pred_taken=0 throughout.
- Stall versus redirect: pc_out=0x10, stall_f=1 for 3 cycles -> pc_out stays 0x10. Then stall_f=1 with redirect_valid=1, redirect_pc=0x203 -> next pc_out=0x200.
- Priority: trap_valid=1 with trap_pc=0x80, plus redirect_valid=1 with redirect_pc=0x40 and stall_f=1 in the same cycle -> pc_out=0x80.
- BTB train, hit and untrain:
  - Update pc=0x20, taken, target=0x100 -> when pc_out reaches 0x20: pred_taken=1, pred_target=0x100, next pc_out=0x100.
  - Then update pc=0x20, not taken -> the next visit to 0x20 gives pred_taken=0 and next pc_out 0x24.
- BTB alias and tag check (BTB_ENTRIES=16): train 0x20->0x100, then train 0x60->0x300 (same idx, different tag) -> 0x20 misses and 0x60 hits. A not-taken update for 0x20 leaves the 0x60 entry valid.
- Wrap and same-index collision:
  - Redirect to 0xFFFFFFFC -> next pc_out 0x00000000.
  - With pc_out=0x20 and a taken update to 0x20 in the same cycle -> pred_taken=0 that cycle and 1 on the next visit.
- BTB_EN=0 build: the trained entry never hits and the PC always advances by 4.

Source files
------------

// File: rtl/pc_unit.sv
// Fetch-stage PC with a direct-mapped BTB: next PC chosen as trap > redirect > stall > BTB hit > PC+4.
// One-cycle redirect latency; stall_f only holds the PC, and flushes and BTB training ignore it.
module pc_unit #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              BTB_ENTRIES  = 16,
   parameter bit              BTB_EN       = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall_f,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_pc,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            btb_upd_valid,
   input  logic [XLEN-1:0] btb_upd_pc,
   input  logic            btb_upd_taken,
   input  logic [XLEN-1:0] btb_upd_target,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] pc_plus4,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target
);

   localparam int IDX_W = $clog2(BTB_ENTRIES);
   localparam int TAG_W = XLEN - IDX_W - 2;

   logic [BTB_ENTRIES-1:0] btb_valid;
   logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
   logic [XLEN-1:0]        btb_target [BTB_ENTRIES];

   logic [IDX_W-1:0] lk_idx;
   logic [IDX_W-1:0] upd_idx;
   logic [TAG_W-1:0] lk_tag;
   logic [TAG_W-1:0] upd_tag;
   logic             hit;
   logic             upd_match;
   logic [XLEN-1:0]  pc_next;
   logic             unused_low_bits;

   assign lk_idx  = pc_out[IDX_W+1:2];
   assign lk_tag  = pc_out[XLEN-1:IDX_W+2];
   assign upd_idx = btb_upd_pc[IDX_W+1:2];
   assign upd_tag = btb_upd_pc[XLEN-1:IDX_W+2];

   // Instructions are word aligned, so address bits [1:0] carry no information here.
   assign unused_low_bits = ^{trap_pc[1:0], redirect_pc[1:0], btb_upd_pc[1:0], btb_upd_target[1:0]};

   assign hit         = BTB_EN && btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
   assign pred_taken  = hit;
   assign pred_target = hit ? btb_target[lk_idx] : '0;
   assign pc_plus4    = pc_out + XLEN'(4);
   assign upd_match   = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);

   always_comb begin
      pc_next = pc_plus4;
      if (trap_valid)
         pc_next = {trap_pc[XLEN-1:2], 2'b00};
      else if (redirect_valid)
         pc_next = {redirect_pc[XLEN-1:2], 2'b00};
      else if (stall_f)
         pc_next = pc_out;
      else if (hit)
         pc_next = pred_target;
   end

   always_ff @(posedge clk) begin
      if (reset)
         pc_out <= RESET_VECTOR;
      else
         pc_out <= pc_next;
   end

   // Lookup reads the pre-edge arrays, so a same-index update is only seen next cycle.
   always_ff @(posedge clk) begin
      if (reset)
         btb_valid <= '0;
      else if (btb_upd_valid) begin
         if (btb_upd_taken)
            btb_valid[upd_idx] <= 1'b1;
         else if (upd_match)
            btb_valid[upd_idx] <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && btb_upd_valid && btb_upd_taken) begin
         btb_tag[upd_idx]    <= upd_tag;
         btb_target[upd_idx] <= {btb_upd_target[XLEN-1:2], 2'b00};
      end
   end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a predicting instance and a BTB_EN=0 instance share the same stimulus.
module tb_pc_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall_f = 1'b0;
   logic        trap_valid = 1'b0;
   logic [31:0] trap_pc = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        btb_upd_valid = 1'b0;
   logic [31:0] btb_upd_pc = '0;
   logic        btb_upd_taken = 1'b0;
   logic [31:0] btb_upd_target = '0;

   logic [31:0] pc_out, pc_plus4, pred_target;
   logic        pred_taken;
   logic [31:0] pc_out0, pc_plus40, pred_target0;
   logic        pred_taken0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pc_unit dut (
      .clk(clk), .reset(reset), .stall_f(stall_f),
      .trap_valid(trap_valid), .trap_pc(trap_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .btb_upd_valid(btb_upd_valid), .btb_upd_pc(btb_upd_pc),
      .btb_upd_taken(btb_upd_taken), .btb_upd_target(btb_upd_target),
      .pc_out(pc_out), .pc_plus4(pc_plus4),
      .pred_taken(pred_taken), .pred_target(pred_target)
   );

   pc_unit #(.BTB_EN(1'b0)) dut_nobtb (
      .clk(clk), .reset(reset), .stall_f(stall_f),
      .trap_valid(trap_valid), .trap_pc(trap_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .btb_upd_valid(btb_upd_valid), .btb_upd_pc(btb_upd_pc),
      .btb_upd_taken(btb_upd_taken), .btb_upd_target(btb_upd_target),
      .pc_out(pc_out0), .pc_plus4(pc_plus40),
      .pred_taken(pred_taken0), .pred_target(pred_target0)
   );

   typedef struct {
      bit          rst, st, tv, rv, uv, ut;
      logic [31:0] tp, rp, up, ug;
      logic [31:0] epc;   // predicting instance, after the edge
      bit          ept;
      logic [31:0] etg;
      logic [31:0] epc0;  // BTB_EN=0 instance, after the edge
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(bit rst, bit st, bit tv, logic [31:0] tp, bit rv, logic [31:0] rp,
                               bit uv, logic [31:0] up, bit ut, logic [31:0] ug,
                               logic [31:0] epc, bit ept, logic [31:0] etg, logic [31:0] epc0);
      vec_t v;
      v.rst = rst; v.st = st; v.tv = tv; v.tp = tp; v.rv = rv; v.rp = rp;
      v.uv = uv; v.up = up; v.ut = ut; v.ug = ug;
      v.epc = epc; v.ept = ept; v.etg = etg; v.epc0 = epc0;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      reset = v.rst; stall_f = v.st;
      trap_valid = v.tv; trap_pc = v.tp;
      redirect_valid = v.rv; redirect_pc = v.rp;
      btb_upd_valid = v.uv; btb_upd_pc = v.up;
      btb_upd_taken = v.ut; btb_upd_target = v.ug;
   endtask

   task automatic idle_inputs();
      vec_t v;
      v = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0);
      drive(v);
   endtask

   initial begin
      //             rst st tv tp       rv rp            uv up     ut ug      epc           pt tgt     epc0
      vecs.push_back(mk(1,0,0,0,        0,0,             0,0,     0,0,       32'h0,        0,0,       32'h0));
      vecs.push_back(mk(1,0,0,0,        0,0,             0,0,     0,0,       32'h0,        0,0,       32'h0));
      vecs.push_back(mk(0,0,0,0,        0,0,             0,0,     0,0,       32'h4,        0,0,       32'h4));
      vecs.push_back(mk(0,0,0,0,        0,0,             0,0,     0,0,       32'h8,        0,0,       32'h8));
      vecs.push_back(mk(0,0,0,0,        0,0,             0,0,     0,0,       32'hC,        0,0,       32'hC));
      vecs.push_back(mk(0,0,0,0,        0,0,             0,0,     0,0,       32'h10,       0,0,       32'h10));
      vecs.push_back(mk(0,1,0,0,        0,0,             0,0,     0,0,       32'h10,       0,0,       32'h10));
      vecs.push_back(mk(0,1,0,0,        0,0,             0,0,     0,0,       32'h10,       0,0,       32'h10));
      vecs.push_back(mk(0,1,0,0,        0,0,             0,0,     0,0,       32'h10,       0,0,       32'h10));
      vecs.push_back(mk(0,1,0,0,        1,32'h203,       0,0,     0,0,       32'h200,      0,0,       32'h200));
      vecs.push_back(mk(0,1,1,32'h80,   1,32'h40,        0,0,     0,0,       32'h80,       0,0,       32'h80));
      vecs.push_back(mk(0,0,0,0,        0,0,             0,0,     0,0,       32'h84,       0,0,       32'h84));
      // train 0x20->0x100, walk up to it
      vecs.push_back(mk(0,0,0,0,        1,32'h18,        1,32'h20,1,32'h100, 32'h18,       0,0,       32'h18));
      vecs.push_back(mk(0,0,0,0,        0,0,             0,0,     0,0,       32'h1C,       0,0,       32'h1C));
      vecs.push_back(mk(0,0,0,0,        0,0,             0,0,     0,0,       32'h20,       1,32'h100, 32'h20));
      vecs.push_back(mk(0,0,0,0,        0,0,             0,0,     0,0,       32'h100,      0,0,       32'h24));
      // untrain 0x20
      vecs.push_back(mk(0,0,0,0,        1,32'h20,        1,32'h20,0,0,       32'h20,       0,0,       32'h20));
      vecs.push_back(mk(0,0,0,0,        0,0,             0,0,     0,0,       32'h24,       0,0,       32'h24));
      // alias: 0x20 and 0x60 share index 8
      vecs.push_back(mk(0,0,0,0,        1,32'h1C,        1,32'h20,1,32'h100, 32'h1C,       0,0,       32'h1C));
      vecs.push_back(mk(0,0,0,0,        0,0,             1,32'h60,1,32'h300, 32'h20,       0,0,       32'h20));
      vecs.push_back(mk(0,0,0,0,        1,32'h60,        0,0,     0,0,       32'h60,       1,32'h300, 32'h60));
      vecs.push_back(mk(0,0,0,0,        1,32'h60,        1,32'h20,0,0,       32'h60,       1,32'h300, 32'h60));
      vecs.push_back(mk(0,0,0,0,        0,0,             0,0,     0,0,       32'h300,      0,0,       32'h64));
      // wrap at the top of the address space
      vecs.push_back(mk(0,0,0,0,        1,32'hFFFFFFFC,  0,0,     0,0,       32'hFFFFFFFC, 0,0,       32'hFFFFFFFC));
      vecs.push_back(mk(0,0,0,0,        0,0,             0,0,     0,0,       32'h0,        0,0,       32'h0));
      // same-index collision: update while pc_out sits on the trained address
      vecs.push_back(mk(0,0,0,0,        1,32'h20,        0,0,     0,0,       32'h20,       0,0,       32'h20));
      vecs.push_back(mk(0,0,0,0,        0,0,             1,32'h20,1,32'h140, 32'h24,       0,0,       32'h24));
      vecs.push_back(mk(0,0,0,0,        1,32'h20,        0,0,     0,0,       32'h20,       1,32'h140, 32'h20));
      vecs.push_back(mk(0,0,0,0,        0,0,             0,0,     0,0,       32'h140,      0,0,       32'h24));
      // stored target drops bits [1:0]; hit visible right after the training edge; stall beats hit
      vecs.push_back(mk(0,0,0,0,        1,32'h40,        1,32'h40,1,32'h203, 32'h40,       1,32'h200, 32'h40));
      vecs.push_back(mk(0,1,0,0,        0,0,             0,0,     0,0,       32'h40,       1,32'h200, 32'h40));
      vecs.push_back(mk(0,0,0,0,        0,0,             0,0,     0,0,       32'h200,      0,0,       32'h44));
      // mid-run reset beats trap and update, and wipes the BTB
      vecs.push_back(mk(1,0,1,32'h80,   0,0,             1,32'h80,1,32'h500, 32'h0,        0,0,       32'h0));
      vecs.push_back(mk(0,0,0,0,        1,32'h40,        0,0,     0,0,       32'h40,       0,0,       32'h40));
      vecs.push_back(mk(0,0,0,0,        1,32'h80,        0,0,     0,0,       32'h80,       0,0,       32'h80));

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i]);
         @(posedge clk);
         #1;
         check($sformatf("row%0d pc_out", i), pc_out, vecs[i].epc);
         check($sformatf("row%0d pc_plus4", i), pc_plus4, vecs[i].epc + 32'd4);
         check($sformatf("row%0d pred_taken", i), {31'b0, pred_taken}, {31'b0, vecs[i].ept});
         check($sformatf("row%0d pred_target", i), pred_target, vecs[i].etg);
         check($sformatf("row%0d nobtb pc_out", i), pc_out0, vecs[i].epc0);
         check($sformatf("row%0d nobtb pred_taken", i), {31'b0, pred_taken0}, 32'h0);
      end

      // Collision seen from inside the cycle: lookup must not bypass the same-edge write.
      @(negedge clk);
      idle_inputs();
      redirect_valid = 1'b1; redirect_pc = 32'h28;
      @(negedge clk);
      idle_inputs();
      btb_upd_valid = 1'b1; btb_upd_pc = 32'h28; btb_upd_taken = 1'b1; btb_upd_target = 32'h400;
      #1;
      check("coll pc_before", pc_out, 32'h28);
      check("coll pred_same_cycle", {31'b0, pred_taken}, 32'h0);
      @(negedge clk);
      idle_inputs();
      check("coll pc_after", pc_out, 32'h2C);
      redirect_valid = 1'b1; redirect_pc = 32'h28;
      @(negedge clk);
      idle_inputs();
      check("coll revisit pred", {31'b0, pred_taken}, 32'h1);
      check("coll revisit target", pred_target, 32'h400);
      check("coll nobtb pred", {31'b0, pred_taken0}, 32'h0);
      @(negedge clk);
      check("coll follow target", pc_out, 32'h400);
      check("coll nobtb seq", pc_out0, 32'h2C);

      // Sequential wrap through the top of memory.
      redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFF8;
      @(negedge clk);
      idle_inputs();
      check("wrap pc_f8", pc_out, 32'hFFFFFFF8);
      @(negedge clk);
      check("wrap pc_fc", pc_out, 32'hFFFFFFFC);
      check("wrap plus4", pc_plus4, 32'h0);
      @(negedge clk);
      check("wrap pc_zero", pc_out, 32'h0);
      check("wrap nobtb zero", pc_out0, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
